// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter that re-arbitrates only at burst ends and
// holds the bus for a master while it keeps its lock request asserted.
module ahb_arbiter #(
    parameter int MASTER_NUM     = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW            = $clog2(MASTER_NUM)
) (
    input  logic                  ahb_clk_in,
    input  logic                  ahb_rst_in,
    input  logic [MASTER_NUM-1:0] master_busreq_in,
    input  logic [MASTER_NUM-1:0] master_lock_in,
    input  logic [1:0]            ahb_trans_in,
    input  logic [2:0]            ahb_burst_in,
    input  logic                  ahb_ready_in,
    input  logic                  ahb_resp_in,
    output logic [MASTER_NUM-1:0] arbiter_grant_out,
    output logic [MW-1:0]         arbiter_master_out,
    output logic                  arbiter_mastlock_out
);
    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MW-1:0]         master_q, master_d, pick;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic                  mastlock_q, mastlock_d;
    logic                  accept, arb, found;
    int                    idx;

    function automatic logic [3:0] burst_last(input logic [2:0] b);
        return b < 3'd2 ? 4'd0 : b < 3'd4 ? 4'd3 : b < 3'd6 ? 4'd7 : 4'd15;
    endfunction

    assign accept = ahb_ready_in && ahb_trans_in[1];

    // An ERROR wait state zeroes the count so the completing edge can re-arbitrate.
    always_comb begin
        cnt_d = cnt_q;
        if (ahb_resp_in && !ahb_ready_in) cnt_d = 4'd0;
        else if (accept && !ahb_trans_in[0]) cnt_d = burst_last(ahb_burst_in);
        else if (accept && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    end

    // Search starts one past the owner so the owner itself is considered last.
    always_comb begin
        found = 1'b0;
        pick  = master_q;
        idx   = 0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            idx = (int'(master_q) + k) % MASTER_NUM;
            if (!found && master_busreq_in[idx]) begin
                found = 1'b1;
                pick  = MW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        master_d = master_q;
        arb      = ahb_ready_in && cnt_d == 4'd0 && !master_lock_in[master_q];
        if (arb) begin
            master_d = found ? pick : MW'(DEFAULT_MASTER);
            state_d  = !found ? PARK : master_lock_in[pick] ? LOCK : OWN;
        end
        grant_d    = {{(MASTER_NUM-1){1'b0}}, 1'b1} << master_d;
        mastlock_d = ahb_ready_in ? master_lock_in[master_d] : mastlock_q;
    end

    always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
        if (ahb_rst_in) begin
            state_q    <= PARK;
            cnt_q      <= 4'd0;
            master_q   <= MW'(DEFAULT_MASTER);
            grant_q    <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
            mastlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            master_q   <= master_d;
            grant_q    <= grant_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign arbiter_grant_out    = grant_q;
    assign arbiter_master_out   = master_q;
    assign arbiter_mastlock_out = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus random traffic, checked against a
// beat-counting reference model of the arbitration rules.
module tb_ahb_arbiter;
    logic       clk = 1'b0, rst = 1'b0;
    logic [3:0] busreq = '0, lock = '0;
    logic [1:0] trans = '0;
    logic [2:0] burst = '0;
    logic       ready = 1'b0, resp = 1'b0;
    logic [3:0] grant;
    logic [1:0] master;
    logic       mastlock;
    int         total = 0, bad = 0;
    int         m_owner = 0, m_left = 0;
    logic       m_ml = 1'b0;
    int         lens[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    ahb_arbiter dut (
        .ahb_clk_in(clk), .ahb_rst_in(rst), .master_busreq_in(busreq),
        .master_lock_in(lock), .ahb_trans_in(trans), .ahb_burst_in(burst),
        .ahb_ready_in(ready), .ahb_resp_in(resp), .arbiter_grant_out(grant),
        .arbiter_master_out(master), .arbiter_mastlock_out(mastlock)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = 0;
        m_left  = 0;
        m_ml    = 1'b0;
    endfunction

    // m_left = beats still owed by the current burst after this edge.
    function automatic void model_edge();
        int nxt;
        if (resp && !ready) m_left = 0;
        else if (ready && trans == 2'd2) m_left = lens[burst] - 1;
        else if (ready && trans == 2'd3 && m_left > 0) m_left = m_left - 1;
        if (ready && m_left == 0 && !lock[m_owner]) begin
            nxt = 0;
            for (int k = 1; k <= 4; k++)
                if (busreq[(m_owner + k) % 4]) begin
                    nxt = (m_owner + k) % 4;
                    break;
                end
            m_owner = nxt;
        end
        if (ready) m_ml = lock[m_owner];
    endfunction

    task automatic cycle(input logic [3:0] br, input logic [3:0] lk, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rd, input logic rs);
        busreq = br; lock = lk; trans = tr; burst = bu; ready = rd; resp = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_grant got=%b exp=0001", grant); end
        total++; if (master !== 2'd0) begin bad++; $display("FAIL reset_master got=%0d exp=0", master); end
        total++; if (mastlock !== 1'b0) begin bad++; $display("FAIL reset_mastlock got=%b exp=0", mastlock); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        cycle(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL park_grant got=%b exp=0001", grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp[4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1011, 4'b0000, 2'd2, 3'd0, 1'b1, 1'b0);
            total++; if (grant !== exp[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, exp[i]); end
            total++; if (int'(master) !== m_owner) begin bad++; $display("FAIL rr_master[%0d] got=%0d exp=%0d", i, master, m_owner); end
        end
    endtask

    task automatic test_incr4();
        logic [1:0] tr[5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic       rd[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        cycle(4'b0100, 4'b0000, 2'd2, 3'd0, 1'b1, 1'b0);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL incr4_setup got=%b exp=0100", grant); end
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 4'b0000, tr[i], 3'd3, rd[i], 1'b0);
            total++; if (grant !== exp[i]) begin bad++; $display("FAIL incr4_grant[%0d] got=%b exp=%b", i, grant, exp[i]); end
            total++; if (int'(master) !== m_owner) begin bad++; $display("FAIL incr4_master[%0d] got=%0d exp=%0d", i, master, m_owner); end
        end
    endtask

    task automatic test_lock();
        cycle(4'b0010, 4'b0010, 2'd2, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 4'b0010, 2'd2, 3'd0, 1'b1, 1'b0);
            total++; if (grant !== 4'b0010) begin bad++; $display("FAIL lock_grant[%0d] got=%b exp=0010", i, grant); end
            total++; if (mastlock !== 1'b1) begin bad++; $display("FAIL lock_mastlock[%0d] got=%b exp=1", i, mastlock); end
        end
        cycle(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 1'b0);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL unlock_grant got=%b exp=0100", grant); end
        total++; if (mastlock !== m_ml) begin bad++; $display("FAIL unlock_mastlock got=%b exp=%b", mastlock, m_ml); end
    endtask

    task automatic test_error();
        logic [1:0] tr[4] = '{2'd2, 2'd3, 2'd3, 2'd3};
        logic       rd[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       rs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp[4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
        cycle(4'b1000, 4'b0000, 2'd2, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111, 4'b0000, tr[i], 3'd5, rd[i], rs[i]);
            total++; if (grant !== exp[i]) begin bad++; $display("FAIL error_grant[%0d] got=%b exp=%b", i, grant, exp[i]); end
        end
    endtask

    task automatic test_reset_mid_lock();
        cycle(4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 1'b0);
        cycle(4'b0100, 4'b0100, 2'd2, 3'd7, 1'b1, 1'b0);
        cycle(4'b1111, 4'b0100, 2'd3, 3'd7, 1'b1, 1'b0);
        total++; if (grant !== 4'b0100 || mastlock !== 1'b1) begin bad++; $display("FAIL midlock_pre got=%b/%b exp=0100/1", grant, mastlock); end
        #2 rst = 1'b1;
        #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL async_grant got=%b exp=0001", grant); end
        total++; if (master !== 2'd0) begin bad++; $display("FAIL async_master got=%0d exp=0", master); end
        total++; if (mastlock !== 1'b0) begin bad++; $display("FAIL async_mastlock got=%b exp=0", mastlock); end
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        cycle(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL post_reset_grant got=%b exp=0100", grant); end
    endtask

    task automatic test_random();
        logic [3:0] lk;
        for (int i = 0; i < 400; i++) begin
            lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            cycle(4'($urandom), lk, 2'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            total++; if (grant !== 4'(1 << m_owner)) begin bad++; $display("FAIL rand_grant[%0d] got=%b exp=%b", i, grant, 4'(1 << m_owner)); end
            total++; if (int'(master) !== m_owner) begin bad++; $display("FAIL rand_master[%0d] got=%0d exp=%0d", i, master, m_owner); end
            total++; if (mastlock !== m_ml) begin bad++; $display("FAIL rand_mastlock[%0d] got=%b exp=%b", i, mastlock, m_ml); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_incr4();
        test_lock();
        test_error();
        test_reset_mid_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 4; number of requesting masters, legal range 2..8.
REQ-002 Parameter DEFAULT_MASTER, default 0; master index parked on when no request is pending.
REQ-003 Port ahb_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 Port ahb_rst_in  input  1  reset is asynchronous and active-high.
REQ-005 Port master_busreq_in  input  MASTER_NUM  per-master bus request, bit i = master i.
REQ-006 Port master_lock_in  input  MASTER_NUM  per-master locked-transfer request.
REQ-007 Port ahb_trans_in  input  2  HTRANS of the current owner: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-008 Port ahb_burst_in  input  3  HBURST of the current owner.
REQ-009 Port ahb_ready_in  input  1  bus HREADY, taken from the multiplexor ready output.
REQ-010 Port ahb_resp_in  input  1  bus response: 0 OKAY, 1 ERROR.
REQ-011 Port arbiter_grant_out  output  MASTER_NUM  one-hot grant, registered.
REQ-012 Port arbiter_master_out  output  $clog2(MASTER_NUM)  index of the granted master, registered.
REQ-013 Port arbiter_mastlock_out  output  1  current transfer is locked, registered.

Function
REQ-014 FSM states: PARK (no requester; default master granted), OWN (requesting master granted), LOCK (owner holding a locked sequence).
REQ-015 Transfer accepted = ahb_ready_in=1 with ahb_trans_in NONSEQ or SEQ; BUSY and IDLE never count as beats.
REQ-016 Beat counter, 4 bits: loaded on an accepted NONSEQ with burst length minus 1 (HBURST 2/3 -> 3, 4/5 -> 7, 6/7 -> 15, 0/1 -> 0); decremented by 1 on each accepted SEQ; saturates at 0.
REQ-017 HBURST 1 (INCR, undefined length) is treated as single beats; an arbitration point follows every accepted beat.
REQ-018 Arbitration point = rising edge with ahb_ready_in=1, counter value after this edge's update = 0, and master_lock_in[owner]=0.
REQ-019 Outside an arbitration point, grant, arbiter_master_out and state hold.
REQ-020 At an arbitration point the new owner is chosen round-robin: search starts at owner+1 modulo MASTER_NUM; first set bit of master_busreq_in wins; the current owner is checked last.
REQ-021 No request at an arbitration point -> grant DEFAULT_MASTER, state PARK.
REQ-022 Request found -> state OWN, or LOCK if master_lock_in of the new owner is 1.
REQ-023 LOCK: grant held regardless of other requests or the counter; exit via REQ-018 once the owner drops master_lock_in.
REQ-024 arbiter_mastlock_out is updated only on edges with ahb_ready_in=1, to master_lock_in[owner after the edge].
REQ-025 ERROR: ahb_resp_in=1 with ahb_ready_in=0 clears the counter to 0, so the completing edge (ready=1) is an arbitration point unless the owner is locked.
REQ-026 Simultaneous load and decrement cannot occur; a NONSEQ accepted while counter>0 reloads the counter (early burst termination).
REQ-027 Grant changes take effect on the edge; the new owner drives its first NONSEQ in the following cycle.
REQ-028 arbiter_grant_out is always exactly one-hot and always equal to 1 << arbiter_master_out.

Reset
REQ-029 ahb_rst_in=1 asynchronously forces state PARK, counter 0, arbiter_grant_out = 1<<DEFAULT_MASTER, arbiter_master_out = DEFAULT_MASTER, arbiter_mastlock_out = 0.
REQ-030 Reset asserted mid-burst or mid-lock abandons the sequence; the first edge after release is an arbitration point if ahb_ready_in=1.

Verification
REQ-031 Reset with busreq=0 -> grant 4'b0001, master 0, mastlock 0, state PARK.
REQ-032 Owner 0, busreq=4'b1011, ready=1, single beats -> grants 1, 3, 0, 1 on successive accepted beats.
REQ-033 Master 2 issues INCR4 (NONSEQ, 3xSEQ) with ready toggling 1,0,1,1,1 and busreq=4'b1111 -> grant stays 4'b0100 until the 4th beat is accepted, then changes to 4'b1000.
REQ-034 Master 1 with lock=1 and busreq=4'b1111 for 6 beats -> grant 4'b0010 and mastlock=1 throughout; lock dropped -> grant moves to master 2 at the next accepted beat.
REQ-035 Master 3 in INCR8, ERROR response on beat 3 (resp=1/ready=0, then resp=1/ready=1) -> grant switches to the next requester on the completing edge.
REQ-036 Reset asserted during a locked INCR16 -> outputs return to REQ-029 values immediately, without waiting for a clock edge.
